// File: rtl/des_round_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// des_round_ctrl_fsm
//
// Round-sequencing controller for iterative Feistel block ciphers. It sits
// beside the L/R datapath and the subkey store and drives their strobes:
// load initial halves, iterate NUM_ROUNDS rounds, capture the result and hold
// it on a valid/ready handshake until the consumer takes it.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   start      block request (IDLE, or HOLD with out_ready=1)
//   decrypt    mode, sampled when start is accepted
//   abort      cancel the block in flight (LOAD/ROUND/LAST only)
//   out_ready  consumer accepts the held result
//   busy       high in LOAD, ROUND and LAST
//   done       one-cycle pulse on the first HOLD cycle
//   aborted    one-cycle pulse the cycle after an abort is honoured
//   round      datapath round index
//   key_idx    subkey index: round (enc) or NUM_ROUNDS-1-round (dec)
//   mode_dec   latched decrypt flag
//   ld_l_r     load L/R registers
//   sel_l_r    0 = initial L0/R0, 1 = round result
//   ld_output  capture final result into the output register
//   out_valid  result available, held until out_ready
// ---------------------------------------------------------------------------
module des_round_ctrl_fsm #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter int unsigned ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               decrypt,
    input  logic               abort,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [ROUND_W-1:0] round,
    output logic [ROUND_W-1:0] key_idx,
    output logic               mode_dec,
    output logic               ld_l_r,
    output logic               sel_l_r,
    output logic               ld_output,
    output logic               out_valid
);

    typedef enum logic [2:0] {StIdle, StLoad, StRound, StLast, StHold} state_e;

    localparam logic [ROUND_W-1:0] LastRound   = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] PenultRound = ROUND_W'(NUM_ROUNDS - 2);

    state_e               state_q, state_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 mode_dec_q, mode_dec_d;
    logic                 abort_hit;

    logic busy_q, ld_l_r_q, sel_l_r_q, ld_last_q, out_valid_q, done_q, aborted_q;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        mode_dec_d = mode_dec_q;
        abort_hit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // start wins over a coincident abort here
                if (start) begin
                    state_d    = StLoad;
                    round_d    = '0;
                    mode_dec_d = decrypt;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d   = StIdle;
                    round_d   = '0;
                    abort_hit = 1'b1;
                end else begin
                    state_d = StRound;
                    round_d = '0;
                end
            end
            StRound: begin
                if (abort) begin
                    state_d   = StIdle;
                    round_d   = '0;
                    abort_hit = 1'b1;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                    if (round_q == PenultRound) begin
                        state_d = StLast;
                    end
                end
            end
            StLast: begin
                if (abort) begin
                    state_d   = StIdle;
                    round_d   = '0;
                    abort_hit = 1'b1;
                end else begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (start) begin
                        state_d    = StLoad;
                        round_d    = '0;
                        mode_dec_d = decrypt;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                round_d = '0;
            end
        endcase
    end

    // State and registered strobes, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            round_q     <= '0;
            mode_dec_q  <= 1'b0;
            busy_q      <= 1'b0;
            ld_l_r_q    <= 1'b0;
            sel_l_r_q   <= 1'b0;
            ld_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            mode_dec_q  <= mode_dec_d;
            busy_q      <= (state_d == StLoad) || (state_d == StRound) || (state_d == StLast);
            ld_l_r_q    <= (state_d == StLoad) || (state_d == StRound);
            sel_l_r_q   <= (state_d == StRound);
            ld_last_q   <= (state_d == StLast);
            out_valid_q <= (state_d == StHold);
            done_q      <= (state_d == StHold) && (state_q != StHold);
            aborted_q   <= abort_hit;
        end
    end

    assign busy      = busy_q;
    assign ld_l_r    = ld_l_r_q;
    assign sel_l_r   = sel_l_r_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign round     = round_q;
    assign mode_dec  = mode_dec_q;

    // An abort arriving in LAST must stop the capture in that same cycle
    assign ld_output = ld_last_q & ~abort;

    assign key_idx = mode_dec_q ? (LastRound - round_q) : round_q;

endmodule

// File: tb/tb_des_round_ctrl_fsm.sv
module tb_des_round_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    // DUT A: 16 rounds, DUT B: 4 rounds
    logic rst_a, start_a, dec_a, abort_a, ready_a;
    logic busy_a, done_a, aborted_a, mode_a, ld_a, sel_a, ldo_a, valid_a;
    logic [3:0] round_a, key_a;

    logic rst_b, start_b, dec_b, abort_b, ready_b;
    logic busy_b, done_b, aborted_b, mode_b, ld_b, sel_b, ldo_b, valid_b;
    logic [1:0] round_b, key_b;

    des_round_ctrl_fsm #(.NUM_ROUNDS(16), .ROUND_W(4)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .decrypt(dec_a), .abort(abort_a),
        .out_ready(ready_a), .busy(busy_a), .done(done_a), .aborted(aborted_a),
        .round(round_a), .key_idx(key_a), .mode_dec(mode_a), .ld_l_r(ld_a),
        .sel_l_r(sel_a), .ld_output(ldo_a), .out_valid(valid_a)
    );

    des_round_ctrl_fsm #(.NUM_ROUNDS(4), .ROUND_W(2)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .decrypt(dec_b), .abort(abort_b),
        .out_ready(ready_b), .busy(busy_b), .done(done_b), .aborted(aborted_b),
        .round(round_b), .key_idx(key_b), .mode_dec(mode_b), .ld_l_r(ld_b),
        .sel_l_r(sel_b), .ld_output(ldo_b), .out_valid(valid_b)
    );

    typedef struct {
        int   cyc;
        logic busy, ld, sel, ldo, valid, done, aborted, mode;
        int   round;
        logic chk_round;
        int   key;
        logic chk_key;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    function automatic exp_t blank(input int c, input logic md);
        exp_t e;
        e.cyc = c; e.busy = 0; e.ld = 0; e.sel = 0; e.ldo = 0; e.valid = 0;
        e.done = 0; e.aborted = 0; e.mode = md;
        e.round = 0; e.chk_round = 0; e.key = 0; e.chk_key = 0;
        return e;
    endfunction

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic exp_t qhead(input int d);
        return (d == 0) ? q_a[0] : q_b[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
    endtask

    // Expected timeline of one block started at cycle t. kind: 0 none,
    // 1 abort in cycle cut, 2 reset asserted in cycle cut. hold = HOLD cycles.
    task automatic push_block(input int d, input int n, input int t, input logic dec,
                              input int cut, input int kind, input int hold);
        exp_t e;
        for (int c = t + 1; c <= t + n + 1 + hold; c++) begin
            e = blank(c, dec);
            if (kind != 0 && c == cut + 1) begin
                e.chk_round = 1;
                if (kind == 1) begin
                    e.aborted = 1;
                end else begin
                    e.mode = 0;
                    e.chk_key = 1;
                end
                qpush(d, e);
                break;
            end
            if (c == t + 1) begin
                e.busy = 1; e.ld = 1; e.chk_round = 1; e.round = 0;
                e.chk_key = 1; e.key = dec ? n - 1 : 0;
            end else if (c <= t + n) begin
                e.busy = 1; e.ld = 1; e.sel = 1; e.chk_round = 1; e.round = c - t - 2;
                e.chk_key = 1; e.key = dec ? n - 1 - e.round : e.round;
            end else if (c == t + n + 1) begin
                e.busy = 1; e.ldo = !(kind == 1 && cut == c);
                e.chk_round = 1; e.round = n - 1;
                e.chk_key = 1; e.key = dec ? 0 : n - 1;
            end else begin
                e.valid = 1; e.done = (c == t + n + 2);
            end
            qpush(d, e);
        end
    endtask

    task automatic push_idle(input int d, input int c, input logic md);
        qpush(d, blank(c, md));
    endtask

    task automatic mon(input int d, input logic busy, input logic ld, input logic sel,
                       input logic ldo, input logic valid, input logic done,
                       input logic ab, input logic mode, input int rnd, input int key);
        exp_t e;
        logic present;
        logic ok;
        present = busy | ld | sel | ldo | valid | done | ab;
        while (qsize(d) > 0 && qhead(d).cyc < cyc) begin
            e = qhead(d);
            nvec++; nerr++;
            $display("FAIL dut%0d missing_output: expected cycle %0d not presented (now %0d)",
                     d, e.cyc, cyc);
            qpop(d);
        end
        if (present === 1'b1 || (qsize(d) > 0 && qhead(d).cyc == cyc)) begin
            nvec++;
            if (qsize(d) == 0) begin
                nerr++;
                $display("FAIL dut%0d unexpected_output cycle %0d: got busy=%b ld=%b sel=%b ldo=%b valid=%b done=%b aborted=%b, want nothing",
                         d, cyc, busy, ld, sel, ldo, valid, done, ab);
            end else begin
                e = qhead(d);
                qpop(d);
                ok = (e.cyc == cyc) && (busy === e.busy) && (ld === e.ld) && (sel === e.sel)
                     && (ldo === e.ldo) && (valid === e.valid) && (done === e.done)
                     && (ab === e.aborted) && (mode === e.mode)
                     && (!e.chk_round || rnd == e.round) && (!e.chk_key || key == e.key);
                if (!ok) begin
                    nerr++;
                    $display("FAIL dut%0d outputs cycle %0d: got busy=%b ld=%b sel=%b ldo=%b valid=%b done=%b aborted=%b mode=%b round=%0d key=%0d; want cycle %0d busy=%b ld=%b sel=%b ldo=%b valid=%b done=%b aborted=%b mode=%b round=%0d(chk %b) key=%0d(chk %b)",
                             d, cyc, busy, ld, sel, ldo, valid, done, ab, mode, rnd, key,
                             e.cyc, e.busy, e.ld, e.sel, e.ldo, e.valid, e.done, e.aborted,
                             e.mode, e.round, e.chk_round, e.key, e.chk_key);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, busy_a, ld_a, sel_a, ldo_a, valid_a, done_a, aborted_a, mode_a,
            int'(round_a), int'(key_a));
        mon(1, busy_b, ld_b, sel_b, ldo_b, valid_b, done_b, aborted_b, mode_b,
            int'(round_b), int'(key_b));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    int t;

    initial begin
        rst_a = 1; start_a = 0; dec_a = 0; abort_a = 0; ready_a = 1;
        rst_b = 1; start_b = 0; dec_b = 0; abort_b = 0; ready_b = 1;
        // Reset state: all outputs 0, round 0
        for (int c = 1; c <= 2; c++) begin
            exp_t e;
            e = blank(c, 0); e.chk_round = 1; e.chk_key = 1;
            qpush(0, e);
            qpush(1, e);
        end
        step(); step();
        rst_a = 0; rst_b = 0;
        goto(4);

        // T1: encrypt, 16 rounds
        t = cyc; start_a = 1; dec_a = 0;
        push_block(0, 16, t, 0, -1, 0, 1); push_idle(0, t + 19, 0);
        step(); start_a = 0;
        goto(t + 21);

        // T2: decrypt, 16 rounds
        t = cyc; start_a = 1; dec_a = 1;
        push_block(0, 16, t, 1, -1, 0, 1); push_idle(0, t + 19, 1);
        step(); start_a = 0; dec_a = 0;
        goto(t + 21);

        // T3: backpressure for 5 HOLD cycles, start/abort ignored, then back-to-back
        t = cyc; ready_a = 0; start_a = 1; dec_a = 0;
        push_block(0, 16, t, 0, -1, 0, 5);
        step(); start_a = 0;
        goto(t + 19); start_a = 1; dec_a = 1; abort_a = 1;
        step(); start_a = 0; dec_a = 0; abort_a = 0;
        goto(t + 22); ready_a = 1; start_a = 1; dec_a = 1;
        push_block(0, 16, t + 22, 1, -1, 0, 1); push_idle(0, t + 22 + 19, 1);
        step(); start_a = 0; dec_a = 0;
        goto(t + 22 + 21);

        // T4: abort at round 7, then a normal block
        t = cyc; start_a = 1; dec_a = 0;
        push_block(0, 16, t, 0, t + 9, 1, 1);
        step(); start_a = 0;
        goto(t + 9); abort_a = 1;
        step(); abort_a = 0;
        goto(t + 12); start_a = 1;
        push_block(0, 16, t + 12, 0, -1, 0, 1); push_idle(0, t + 12 + 19, 0);
        step(); start_a = 0;
        goto(t + 12 + 21);

        // T5: reset at round 10, then a fresh decrypt block
        t = cyc; start_a = 1; dec_a = 1;
        push_block(0, 16, t, 1, t + 12, 2, 1);
        step(); start_a = 0;
        goto(t + 12); rst_a = 1;
        step(); rst_a = 0;
        goto(t + 15); start_a = 1; dec_a = 1;
        push_block(0, 16, t + 15, 1, -1, 0, 1); push_idle(0, t + 15 + 19, 1);
        step(); start_a = 0; dec_a = 0;
        goto(t + 15 + 21);

        // T6a: 4 rounds decrypt; abort coincident with start in IDLE is ignored
        t = cyc; start_b = 1; abort_b = 1; dec_b = 1;
        push_block(1, 4, t, 1, -1, 0, 1); push_idle(1, t + 7, 1);
        step(); start_b = 0; abort_b = 0; dec_b = 0;
        goto(t + 9);

        // T6b: abort coincident with LAST suppresses ld_output
        t = cyc; start_b = 1; dec_b = 1;
        push_block(1, 4, t, 1, t + 5, 1, 1);
        step(); start_b = 0; dec_b = 0;
        goto(t + 5); abort_b = 1;
        step(); abort_b = 0;
        goto(t + 10);

        step(); step();
        for (int d = 0; d < 2; d++) begin
            if (qsize(d) != 0) begin
                nvec++; nerr++;
                $display("FAIL dut%0d leftover_expectations: %0d entries unconsumed, want 0",
                         d, qsize(d));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
